// File: rtl/serial_block_link.sv
// Byte-stream front end for a block-cipher core: parses 'K'/'D' commands, assembles
// key/plaintext, hands plaintext to the core and serialises the result back out.
module serial_block_link #(
  parameter int unsigned BLOCK_BYTES    = 16,
  parameter int unsigned KEY_BYTES      = 16,
  parameter logic [7:0]  CMD_KEY        = 8'h4B,
  parameter logic [7:0]  CMD_DATA       = 8'h44,
  parameter logic [7:0]  ACK_BYTE       = 8'h52,
  parameter logic [7:0]  ERR_BYTE       = 8'h45,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [7:0]               RxByte,
  input  logic                     RxValid,
  output logic [7:0]               TxByte,
  output logic                     TxValid,
  input  logic                     TxReady,
  output logic [8*KEY_BYTES-1:0]   Key,
  output logic                     KeyRy,
  output logic                     KeyLoad,
  output logic [8*BLOCK_BYTES-1:0] PT,
  output logic                     PTValid,
  input  logic                     PTReady,
  input  logic [8*BLOCK_BYTES-1:0] Result,
  input  logic                     ResultValid,
  output logic                     ResultReady,
  output logic                     Busy,
  output logic                     Overrun
);

  localparam int unsigned KeyW     = 8 * KEY_BYTES;
  localparam int unsigned BlkW     = 8 * BLOCK_BYTES;
  localparam int unsigned MaxBytes = (KEY_BYTES > BLOCK_BYTES) ? KEY_BYTES : BLOCK_BYTES;
  localparam int unsigned BufW     = 8 * MaxBytes;
  localparam int unsigned CntW     = $clog2(MaxBytes + 1);
  localparam int unsigned ToW      = $clog2(TIMEOUT_CYCLES);

  localparam logic [CntW-1:0] KeyLast = CntW'(KEY_BYTES - 1);
  localparam logic [CntW-1:0] BlkLast = CntW'(BLOCK_BYTES - 1);
  localparam logic [ToW-1:0]  ToLast  = ToW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_ACK, S_CMD, S_RX, S_PT, S_RES, S_TX, S_ERR} stateT;

  stateT            state;
  logic             isKey;
  logic [CntW-1:0]  byteCnt;
  logic [ToW-1:0]   toCnt;
  logic [BufW-1:0]  asmBuf;
  logic [BlkW-1:0]  txShift;
  logic [BufW-1:0]  shifted;

  // Big-endian assembly: earlier bytes migrate towards the MSB
  assign shifted = {asmBuf[BufW-9:0], RxByte};

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state       <= S_ACK;
      isKey       <= 1'b0;
      byteCnt     <= '0;
      toCnt       <= '0;
      asmBuf      <= '0;
      txShift     <= '0;
      TxByte      <= '0;
      TxValid     <= 1'b0;
      Key         <= '0;
      KeyRy       <= 1'b0;
      KeyLoad     <= 1'b0;
      PT          <= '0;
      PTValid     <= 1'b0;
      ResultReady <= 1'b0;
      Busy        <= 1'b1;
      Overrun     <= 1'b0;
    end else begin
      KeyLoad <= 1'b0;
      if (RxValid && state != S_CMD && state != S_RX) Overrun <= 1'b1;

      case (state)
        S_ACK: begin
          if (TxValid && TxReady) begin
            TxValid <= 1'b0;
            Overrun <= 1'b0;
            Busy    <= 1'b0;
            state   <= S_CMD;
          end else if (!TxValid) begin
            TxValid <= 1'b1;
            TxByte  <= ACK_BYTE;
          end
        end

        S_CMD: begin
          if (RxValid) begin
            Busy    <= 1'b1;
            byteCnt <= '0;
            toCnt   <= '0;
            asmBuf  <= '0;
            if (RxByte == CMD_KEY) begin
              isKey <= 1'b1;
              state <= S_RX;
            end else if (RxByte == CMD_DATA) begin
              isKey <= 1'b0;
              state <= S_RX;
            end else begin
              state <= S_ERR;
            end
          end
        end

        S_RX: begin
          if (RxValid) begin
            asmBuf <= shifted;
            toCnt  <= '0;
            if (byteCnt == (isKey ? KeyLast : BlkLast)) begin
              if (isKey) begin
                Key     <= shifted[KeyW-1:0];
                KeyLoad <= 1'b1;
                KeyRy   <= 1'b1;
                state   <= S_ACK;
              end else begin
                PT      <= shifted[BlkW-1:0];
                PTValid <= 1'b1;
                state   <= S_PT;
              end
            end else begin
              byteCnt <= byteCnt + CntW'(1);
            end
          end else if (toCnt == ToLast) begin
            asmBuf <= '0;
            toCnt  <= '0;
            state  <= S_ERR;
          end else begin
            toCnt <= toCnt + ToW'(1);
          end
        end

        S_PT: begin
          if (PTReady) begin
            PTValid     <= 1'b0;
            ResultReady <= 1'b1;
            state       <= S_RES;
          end
        end

        S_RES: begin
          if (ResultValid) begin
            ResultReady <= 1'b0;
            TxByte      <= Result[BlkW-1 -: 8];
            txShift     <= {Result[BlkW-9:0], 8'h00};
            TxValid     <= 1'b1;
            byteCnt     <= '0;
            state       <= S_TX;
          end
        end

        S_TX: begin
          if (TxReady) begin
            if (byteCnt == BlkLast) begin
              TxValid <= 1'b0;
              state   <= S_ACK;
            end else begin
              TxByte  <= txShift[BlkW-1 -: 8];
              txShift <= {txShift[BlkW-9:0], 8'h00};
              byteCnt <= byteCnt + CntW'(1);
            end
          end
        end

        S_ERR: begin
          if (TxValid && TxReady) begin
            TxValid <= 1'b0;
            Busy    <= 1'b0;
            state   <= S_CMD;
          end else if (!TxValid) begin
            TxValid <= 1'b1;
            TxByte  <= ERR_BYTE;
          end
        end

        default: state <= S_ACK;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_block_link.sv
// Scoreboard bench for serial_block_link: expected TX bytes are queued as stimulus is
// driven and popped by a monitor on every accepted TX handshake.
module tb_serial_block_link;
  localparam int unsigned BB = 16;
  localparam int unsigned KB = 16;
  localparam int unsigned KBW = 32;
  localparam int unsigned TO = 50;

  logic             Clk = 1'b0;
  logic             Rst = 1'b1;
  logic [7:0]       RxByte = '0;
  logic             RxValid = 1'b0;
  logic [7:0]       TxByte;
  logic             TxValid;
  logic             TxReady = 1'b0;
  logic [8*KB-1:0]  Key;
  logic             KeyRy, KeyLoad;
  logic [8*BB-1:0]  PT;
  logic             PTValid;
  logic             PTReady = 1'b0;
  logic [8*BB-1:0]  Result = '0;
  logic             ResultValid = 1'b0;
  logic             ResultReady, Busy, Overrun;

  logic [7:0]       rxByteW = '0;
  logic             rxValidW = 1'b0;
  logic [7:0]       txByteW;
  logic             txValidW;
  logic [8*KBW-1:0] keyW;
  logic             keyRyW, keyLoadW;
  logic [8*BB-1:0]  ptW;
  logic             ptValidW, resultReadyW, busyW, overrunW;

  int checks = 0;
  int errors = 0;
  logic [7:0] txq[$];
  logic [7:0] expB;
  logic [8*KB-1:0] lastKey;

  always #5 Clk = ~Clk;

  serial_block_link #(.BLOCK_BYTES(BB), .KEY_BYTES(KB), .TIMEOUT_CYCLES(TO)) dut (
    .Clk(Clk), .Rst(Rst), .RxByte(RxByte), .RxValid(RxValid),
    .TxByte(TxByte), .TxValid(TxValid), .TxReady(TxReady),
    .Key(Key), .KeyRy(KeyRy), .KeyLoad(KeyLoad),
    .PT(PT), .PTValid(PTValid), .PTReady(PTReady),
    .Result(Result), .ResultValid(ResultValid), .ResultReady(ResultReady),
    .Busy(Busy), .Overrun(Overrun)
  );

  serial_block_link #(.BLOCK_BYTES(BB), .KEY_BYTES(KBW), .TIMEOUT_CYCLES(TO)) dutWide (
    .Clk(Clk), .Rst(Rst), .RxByte(rxByteW), .RxValid(rxValidW),
    .TxByte(txByteW), .TxValid(txValidW), .TxReady(1'b1),
    .Key(keyW), .KeyRy(keyRyW), .KeyLoad(keyLoadW),
    .PT(ptW), .PTValid(ptValidW), .PTReady(1'b0),
    .Result('0), .ResultValid(1'b0), .ResultReady(resultReadyW),
    .Busy(busyW), .Overrun(overrunW)
  );

  // TX scoreboard monitor
  always @(negedge Clk) begin
    if (!Rst && TxValid && TxReady) begin
      checks++;
      if (txq.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected got %h required none", TxByte);
      end else begin
        expB = txq.pop_front();
        if (TxByte !== expB) begin
          errors++;
          $display("FAIL tx_byte got %h required %h", TxByte, expB);
        end
      end
    end
  end

  task automatic sendRx(input logic [7:0] b);
    @(posedge Clk); #1;
    RxByte = b; RxValid = 1'b1;
    @(posedge Clk); #1;
    RxValid = 1'b0;
  endtask

  task automatic sendRxW(input logic [7:0] b);
    @(posedge Clk); #1;
    rxByteW = b; rxValidW = 1'b1;
    @(posedge Clk); #1;
    rxValidW = 1'b0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 2000 && txq.size() != 0; i++) @(negedge Clk);
    @(posedge Clk); #1;
  endtask

  task automatic test_reset();
    Rst = 1'b1; TxReady = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    checks++;
    if ({TxValid, TxByte, KeyRy, KeyLoad, PTValid, ResultReady, Overrun} !== '0 ||
        Key !== '0 || PT !== '0) begin
      errors++;
      $display("FAIL reset_outputs got tv=%b tb=%h key=%h pt=%h required all 0", TxValid, TxByte, Key, PT);
    end
    txq.push_back(8'h52);
    TxReady = 1'b1;
    Rst = 1'b0;
    waitDrain();
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if (txq.size() != 0 || Busy !== 1'b0 || TxValid !== 1'b0 || KeyRy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ack got pending=%0d busy=%b tv=%b required 0 0 0", txq.size(), Busy, TxValid);
      txq.delete();
    end
  endtask

  task automatic test_key(input logic [7:0] base);
    logic [8*KB-1:0] expKey;
    expKey = '0;
    sendRx(8'h4B);
    for (int i = 0; i < KB; i++) begin
      expKey = {expKey[8*KB-9:0], base + 8'(i)};
      sendRx(base + 8'(i));
    end
    txq.push_back(8'h52);
    checks++;
    if (Key !== expKey || KeyLoad !== 1'b1 || KeyRy !== 1'b1) begin
      errors++;
      $display("FAIL key_load got key=%h ld=%b ry=%b required %h 1 1", Key, KeyLoad, KeyRy, expKey);
    end
    @(posedge Clk); #1;
    checks++;
    if (KeyLoad !== 1'b0 || Key !== expKey) begin
      errors++;
      $display("FAIL key_pulse got ld=%b required 0", KeyLoad);
    end
    lastKey = expKey;
    waitDrain();
    checks++;
    if (txq.size() != 0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL key_ack got pending=%0d busy=%b required 0 0", txq.size(), Busy);
      txq.delete();
    end
  endtask

  task automatic test_data();
    logic [8*BB-1:0] expPT;
    expPT = '0;
    PTReady = 1'b0;
    sendRx(8'h44);
    for (int i = 0; i < BB; i++) begin
      expPT = {expPT[8*BB-9:0], 8'h10 + 8'(i)};
      sendRx(8'h10 + 8'(i));
    end
    checks++;
    if (PTValid !== 1'b1 || PT !== expPT) begin
      errors++;
      $display("FAIL data_pt got v=%b pt=%h required 1 %h", PTValid, PT, expPT);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge Clk); #1;
      checks++;
      if (PTValid !== 1'b1 || PT !== expPT) begin
        errors++;
        $display("FAIL data_hold got v=%b pt=%h required 1 %h", PTValid, PT, expPT);
      end
    end
    PTReady = 1'b1;
    @(posedge Clk); #1;
    PTReady = 1'b0;
    checks++;
    if (PTValid !== 1'b0 || ResultReady !== 1'b1 || Key !== lastKey) begin
      errors++;
      $display("FAIL data_handoff got v=%b rr=%b key=%h required 0 1 %h", PTValid, ResultReady, Key, lastKey);
    end
    repeat (3) @(posedge Clk);
    #1;
    Result = {BB{8'hA5}};
    ResultValid = 1'b1;
    for (int i = 0; i < BB; i++) txq.push_back(8'hA5);
    txq.push_back(8'h52);
    @(posedge Clk); #1;
    ResultValid = 1'b0;
    checks++;
    if (ResultReady !== 1'b0) begin
      errors++;
      $display("FAIL data_rr got %b required 0", ResultReady);
    end
    sendRx(8'h33);
    checks++;
    if (Overrun !== 1'b1 || PT !== expPT) begin
      errors++;
      $display("FAIL overrun_set got ov=%b pt=%h required 1 %h", Overrun, PT, expPT);
    end
    waitDrain();
    checks++;
    if (txq.size() != 0 || Overrun !== 1'b0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear got pending=%0d ov=%b busy=%b required 0 0 0", txq.size(), Overrun, Busy);
      txq.delete();
    end
  endtask

  task automatic test_back_to_back();
    logic [8*BB-1:0] res;
    logic pat [4];
    logic prevStall;
    logic [7:0] prevByte;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    res = 128'h00112233445566778899AABBCCDDEEFF;
    PTReady = 1'b1;
    sendRx(8'h44);
    for (int i = 0; i < BB; i++) sendRx(8'hC0 + 8'(i));
    checks++;
    if (PTValid !== 1'b1) begin
      errors++;
      $display("FAIL pt_first got %b required 1", PTValid);
    end
    @(posedge Clk); #1;
    PTReady = 1'b0;
    checks++;
    if (PTValid !== 1'b0 || ResultReady !== 1'b1) begin
      errors++;
      $display("FAIL pt_immediate got v=%b rr=%b required 0 1", PTValid, ResultReady);
    end
    Result = res;
    ResultValid = 1'b1;
    for (int i = 0; i < BB; i++) txq.push_back(res[8*BB-1-8*i -: 8]);
    txq.push_back(8'h52);
    @(posedge Clk); #1;
    ResultValid = 1'b0;
    prevStall = 1'b0;
    prevByte = '0;
    for (int k = 0; k < 400 && txq.size() != 0; k++) begin
      TxReady = pat[k % 4];
      @(negedge Clk);
      if (prevStall && TxValid) begin
        checks++;
        if (TxByte !== prevByte) begin
          errors++;
          $display("FAIL tx_stable got %h required %h", TxByte, prevByte);
        end
      end
      prevStall = TxValid && !TxReady;
      prevByte = TxByte;
      @(posedge Clk); #1;
    end
    TxReady = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    checks++;
    if (txq.size() != 0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_drain got pending=%0d busy=%b required 0 0", txq.size(), Busy);
      txq.delete();
    end
  endtask

  task automatic test_timeout();
    int n;
    sendRx(8'h44);
    for (int i = 0; i < 3; i++) sendRx(8'h77);
    txq.push_back(8'h45);
    n = 0;
    while (!TxValid && n < 200) begin
      @(posedge Clk); #1;
      n++;
    end
    checks++;
    if (n < int'(TO) - 1 || n > int'(TO) + 3) begin
      errors++;
      $display("FAIL timeout_latency got %0d required %0d..%0d", n, TO - 1, TO + 3);
    end
    waitDrain();
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if (txq.size() != 0 || Busy !== 1'b0 || TxValid !== 1'b0 || PTValid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_err got pending=%0d busy=%b tv=%b required 0 0 0", txq.size(), Busy, TxValid);
      txq.delete();
    end
    test_key(8'hF0);
  endtask

  task automatic test_unknown();
    sendRx(8'h00);
    txq.push_back(8'h45);
    waitDrain();
    repeat (10) @(posedge Clk);
    #1;
    checks++;
    if (txq.size() != 0 || Busy !== 1'b0 || TxValid !== 1'b0 || Key !== lastKey) begin
      errors++;
      $display("FAIL unknown_cmd got pending=%0d busy=%b tv=%b required 0 0 0", txq.size(), Busy, TxValid);
      txq.delete();
    end
  endtask

  task automatic test_reset_mid();
    sendRx(8'h4B);
    for (int i = 0; i < 5; i++) sendRx(8'h99);
    Rst = 1'b1;
    #1;
    checks++;
    if ({TxValid, KeyRy, KeyLoad, PTValid, ResultReady, Overrun} !== '0 || Key !== '0 || PT !== '0) begin
      errors++;
      $display("FAIL reset_mid got key=%h ry=%b pt=%h required 0 0 0", Key, KeyRy, PT);
    end
    @(posedge Clk); #1;
    txq.push_back(8'h52);
    Rst = 1'b0;
    waitDrain();
    checks++;
    if (txq.size() != 0 || Busy !== 1'b0 || KeyRy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_ack got pending=%0d busy=%b ry=%b required 0 0 0", txq.size(), Busy, KeyRy);
      txq.delete();
    end
  endtask

  task automatic test_wide_key();
    logic [8*KBW-1:0] expKey;
    expKey = '0;
    repeat (5) @(posedge Clk);
    sendRxW(8'h4B);
    for (int i = 0; i < KBW; i++) begin
      expKey = {expKey[8*KBW-9:0], 8'(3 * i + 1)};
      sendRxW(8'(3 * i + 1));
    end
    checks++;
    if (keyW !== expKey || keyLoadW !== 1'b1 || keyRyW !== 1'b1) begin
      errors++;
      $display("FAIL wide_key got %h ld=%b required %h 1", keyW, keyLoadW, expKey);
    end
  endtask

  initial begin
    test_reset();
    test_key(8'h00);
    test_data();
    test_back_to_back();
    test_timeout();
    test_unknown();
    test_reset_mid();
    test_wide_key();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
